// File: rtl/gpr_bank.sv
// rtl/gpr_bank.sv - general-purpose register bank: C-bus write, increment port, registered B-bus read
// Optional define GPR_BANK_BYPASS_EN: the B-bus read sees same-edge load/increment results.
module gpr_bank #(
    parameter int              WIDTH     = 24,
    parameter int              NREG      = 6,
    parameter int              SELW      = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [SELW-1:0]       wr_sel,
    input  logic [WIDTH-1:0]      C_bus,
    input  logic                  inc,
    input  logic [SELW-1:0]       inc_sel,
    input  logic [SELW-1:0]       rd_sel,
    output logic [WIDTH-1:0]      B_bus,
    output logic                  z_flag,
    output logic                  wrap,
    output logic [NREG*WIDTH-1:0] regs_flat
);

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [WIDTH-1:0] b_q, b_d;
    logic             z_q, z_d;
    logic             wrap_q, wrap_d;

    logic load_hit;
    logic inc_hit;

    // Out-of-range selects never match any register index below, so they are no-ops.
    assign load_hit = load;
    assign inc_hit  = inc && !(load && (wr_sel == inc_sel));

    always_comb begin
        wrap_d = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (inc_hit && (inc_sel == SELW'(i))) begin
                regs_d[i] = regs_q[i] + WIDTH'(1);
                if (&regs_q[i]) begin
                    wrap_d = 1'b1;
                end
            end
            if (load_hit && (wr_sel == SELW'(i))) begin
                regs_d[i] = C_bus;
            end
        end
    end

    always_comb begin
        b_d = '0;
        for (int i = 0; i < NREG; i++) begin
            if (rd_sel == SELW'(i)) begin
`ifdef GPR_BANK_BYPASS_EN
                b_d = regs_d[i];
`else
                b_d = regs_q[i];
`endif
            end
        end
        z_d = (b_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            b_q    <= RESET_VAL;
            z_q    <= (RESET_VAL == '0);
            wrap_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            b_q    <= b_d;
            z_q    <= z_d;
            wrap_q <= wrap_d;
        end
    end

    assign B_bus  = b_q;
    assign z_flag = z_q;
    assign wrap   = wrap_q;

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
    end

endmodule

// File: doc/gpr_bank.md
# gpr_bank

Parametrised bank of general-purpose registers replacing individually instantiated R1–R4, R and AC registers. It provides:
- one write port from the C bus;
- one independent increment port, used for AC/R counting;
- one registered read port onto the B bus, with a zero flag;
- a flat view of every register for datapath taps.

It sits between the ALU result bus (C_bus) and the ALU operand bus (B_bus) in the processor datapath.

## Interface
- WIDTH, 24, data width of every register and bus
- NREG, 6, number of registers (2..2^SELW)
- SELW, 3, width of select fields
- RESET_VAL, 0, value loaded into every register on reset
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- load  in  1  write C_bus into register wr_sel
- wr_sel  in  SELW  write target index
- C_bus  in  WIDTH  write data
- inc  in  1  increment register inc_sel by 1
- inc_sel  in  SELW  increment target index
- rd_sel  in  SELW  read source index
- B_bus  out  WIDTH  registered read data
- z_flag  out  1  registered, high when B_bus value is zero
- wrap  out  1  one-cycle pulse: an increment rolled over all-ones to zero
- regs_flat  out  NREG*WIDTH  all registers; register i at bits [i*WIDTH +: WIDTH]

## Operation
- State: NREG registers of WIDTH bits, plus the B_bus, z_flag and wrap output registers.
- Reset (rst high at posedge):
  - every register becomes RESET_VAL;
  - B_bus becomes RESET_VAL; z_flag becomes (RESET_VAL==0);
  - wrap becomes 0;
  - pending load/inc in that cycle are discarded.
- Reset has priority over all other inputs; asserting it mid-sequence aborts any operation with no partial update.
- Write: load high and wr_sel < NREG → reg[wr_sel] takes C_bus at the edge.
- Increment: inc high and inc_sel < NREG → reg[inc_sel] takes reg[inc_sel]+1, modulo 2^WIDTH.
- Same cycle, different targets: load and inc both take effect.
- Same cycle, same target: load wins; the increment is dropped and wrap stays 0.
- wrap:
  - high for exactly the cycle after an edge where an executed increment took all-ones to zero;
  - otherwise 0.
- Out-of-range select (index ≥ NREG):
  - load/inc are ignored; no register changes, wrap stays 0;
  - reading yields 0 on B_bus and z_flag=1.
- Read:
  - B_bus captures reg[rd_sel] at every edge;
  - z_flag captures (captured value == 0) in the same edge.
- regs_flat is combinational from the register state; it changes only at clock edges.
- No handshake; the bank accepts one load and one inc every cycle.

## Timing
- Write/increment latency: 1 cycle; the new value is visible on regs_flat after the edge.
- Read latency: 1 cycle from rd_sel to B_bus/z_flag.
- Read-during-write to the same index without bypass: B_bus gets the pre-edge (old) value; the new value appears one edge later.
- wrap is asserted in the cycle after the rollover edge and deasserts on the following edge unless another rollover occurs.
- B_bus, z_flag and wrap are all registered outputs with no combinational path from inputs.

## Configuration
- Macro: GPR_BANK_BYPASS_EN.
- Defined:
  - B_bus and z_flag capture the next-state value of reg[rd_sel], including same-edge load/inc;
  - resulting read-after-write latency: 1 cycle from the load cycle;
  - load-over-inc priority still applies;
  - reset still forces B_bus to RESET_VAL.
- Undefined: B_bus captures the current (pre-edge) value as described above.
- Either way: register, wrap and regs_flat behaviour is identical.

## Test plan
- Reset: rst=1 one edge with RESET_VAL=0 → all regs_flat fields 0, B_bus=0, z_flag=1, wrap=0; then load=1, wr_sel=2, C_bus=24'h00ABCD → reg2=24'h00ABCD next cycle, rd_sel=2 → B_bus=24'h00ABCD, z_flag=0 one cycle later.
- Wrap: load reg5=24'hFFFFFE, then inc inc_sel=5 two cycles → reg5=24'hFFFFFF then 24'h000000; wrap=1 only in the cycle after the second increment.
- Collision: reg1=24'h000010; same cycle load wr_sel=1 C_bus=24'h000100 and inc inc_sel=1 → reg1=24'h000100, wrap=0.
- Parallel ops: same cycle load reg0=24'h000007, inc reg3 (from 24'h000001) → reg0=24'h000007, reg3=24'h000002.
- Out of range: wr_sel=6, inc_sel=7, rd_sel=7 with load/inc high → no register changes, B_bus=0, z_flag=1.
- Read-during-write: reg4=24'h000005; load reg4=24'h000009 with rd_sel=4 → B_bus=24'h000005 without GPR_BANK_BYPASS_EN, 24'h000009 with it; rst asserted in the following cycle → B_bus=0.
